// File: rtl/msrv32_instr_fetch_unit.sv
// msrv32_instr_fetch_unit: fetch PC sequencer with single-outstanding imem handshake and output/skid buffering.
// Define MSRV32_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of silently aligning them.
module msrv32_instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] FLUSH_WORD = 32'h0000_0013
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        redirect_in,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic        flush_out
`ifdef MSRV32_MISALIGN_TRAP_EN
    ,
    output logic        misaligned_out
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, TRAP} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_fetch_pc, r_instr, r_pc, r_skid_instr, r_skid_pc;
    logic        r_valid, r_flush, r_skid_valid, r_drop;
    logic        w_accept, w_take, w_out_free, w_owed, w_mis;
    logic [31:0] w_target, w_rsp_pc;
    assign w_target = pc_in & ~32'h3;
`ifdef MSRV32_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_mis          = redirect_in && (pc_in[1:0] != 2'b00);
    assign misaligned_out = r_mis;
    always_ff @(posedge ms_riscv32_mp_clk_in)
        r_mis <= ms_riscv32_mp_rst_in ? 1'b0 : w_mis;
`else
    assign w_mis = 1'b0;
`endif
    assign imem_req_out    = (r_state == REQ) && !r_skid_valid && !r_drop;
    assign imem_addr_out   = r_fetch_pc;
    assign w_accept        = imem_req_out && imem_ready_in;
    assign w_take          = imem_rvalid_in && (r_state == WAIT) && !r_drop && !redirect_in;
    assign w_rsp_pc        = r_fetch_pc - 32'd4;
    assign w_out_free      = !r_valid || !stall_in;
    // a response is still owed by memory and must be swallowed when it shows up
    assign w_owed          = ((r_state == WAIT) || r_drop) && !imem_rvalid_in;
    assign instr_out       = r_instr;
    assign pc_out          = r_pc;
    assign instr_valid_out = r_valid;
    assign flush_out       = r_flush;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = REQ;
            REQ:     w_next = w_accept ? WAIT : REQ;
            WAIT:    w_next = !imem_rvalid_in ? WAIT : (w_out_free && !r_skid_valid) ? REQ : HOLD;
            HOLD:    w_next = w_out_free ? REQ : HOLD;
            default: w_next = TRAP;
        endcase
        if (redirect_in)
            w_next = w_mis ? TRAP : REQ;
    end
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_instr      <= FLUSH_WORD;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_flush      <= 1'b1;
            r_skid_valid <= 1'b0;
            r_skid_instr <= FLUSH_WORD;
            r_skid_pc    <= RESET_PC;
            r_drop       <= w_owed || w_accept;
        end else begin
            r_state <= w_next;
            r_drop  <= redirect_in ? (w_owed || w_accept) : (r_drop && !imem_rvalid_in);
            if (redirect_in)
                r_fetch_pc <= w_target;
            else if (w_accept)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (redirect_in) begin
                r_valid      <= 1'b0;
                r_instr      <= FLUSH_WORD;
                r_flush      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                if (r_skid_valid) begin
                    r_instr      <= r_skid_instr;
                    r_pc         <= r_skid_pc;
                    r_valid      <= 1'b1;
                    r_flush      <= 1'b0;
                    r_skid_valid <= w_take;
                    r_skid_instr <= imem_rdata_in;
                    r_skid_pc    <= w_rsp_pc;
                end else if (w_take) begin
                    r_instr <= imem_rdata_in;
                    r_pc    <= w_rsp_pc;
                    r_valid <= 1'b1;
                    r_flush <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                    r_instr <= FLUSH_WORD;
                end
            end else if (w_take) begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= imem_rdata_in;
                r_skid_pc    <= w_rsp_pc;
            end
        end
    end
endmodule

// File: tb/tb_msrv32_instr_fetch_unit.sv
// tb_msrv32_instr_fetch_unit: directed cycle-by-cycle bench with a latency-programmable instruction memory model.
module tb_msrv32_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, redirect, stall, ready, rvalid;
    logic [31:0] pc_in, rdata;
    logic        req, valid, flush;
    logic [31:0] addr, instr, pc_out;
`ifdef MSRV32_MISALIGN_TRAP_EN
    logic        mis;
`endif
    int          checks = 0;
    int          errors = 0;
    int          lat, p_cnt;
    logic        p_busy;
    logic [31:0] p_addr;

    msrv32_instr_fetch_unit dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .redirect_in(redirect),
        .pc_in(pc_in),
        .stall_in(stall),
        .imem_req_out(req),
        .imem_addr_out(addr),
        .imem_ready_in(ready),
        .imem_rvalid_in(rvalid),
        .imem_rdata_in(rdata),
        .instr_out(instr),
        .pc_out(pc_out),
        .instr_valid_out(valid),
        .flush_out(flush)
`ifdef MSRV32_MISALIGN_TRAP_EN
        ,
        .misaligned_out(mis)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a == 32'h4) ? 32'h0010_8113 : {a[23:0], 8'h93};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: capture an accept before the edge, then play the memory response #1 after it
    task automatic tick();
        @(negedge clk);
        if (req && ready) begin
            p_busy = 1'b1;
            p_addr = addr;
            p_cnt  = lat;
        end
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        if (p_busy) begin
            if (p_cnt == 0) begin
                rvalid = 1'b1;
                rdata  = word(p_addr);
                p_busy = 1'b0;
            end else
                p_cnt--;
        end
    endtask

    initial begin
        rst = 1; redirect = 0; pc_in = 0; stall = 0; ready = 1; rvalid = 0; rdata = 0;
        lat = 0; p_cnt = 0; p_busy = 0; p_addr = 0;
        tick(); tick();
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_flush", {31'b0, flush}, 1);
        rst = 0;
        tick();
        chk("t1_req0", {31'b0, req}, 1);
        chk("t1_addr0", addr, 32'h0);
        tick();
        chk("t1_wait_req", {31'b0, req}, 0);
        chk("t1_flush_pre", {31'b0, flush}, 1);
        tick();
        chk("t1_instr0", instr, 32'h0050_0093);
        chk("t1_pc0", pc_out, 32'h0);
        chk("t1_valid0", {31'b0, valid}, 1);
        chk("t1_flush_fall", {31'b0, flush}, 0);
        chk("t1_addr4", addr, 32'h4);
        tick();
        chk("t1_bubble_valid", {31'b0, valid}, 0);
        chk("t1_bubble_instr", instr, 32'h13);
        tick();
        chk("t1_instr1", instr, 32'h0010_8113);
        chk("t1_pc1", pc_out, 32'h4);
        chk("t1_addr8", addr, 32'h8);
        stall = 1;
        tick(); tick();
        chk("t2_hold_instr", instr, 32'h0010_8113);
        chk("t2_hold_valid", {31'b0, valid}, 1);
        chk("t2_skid_full_req", {31'b0, req}, 0);
        tick(); tick();
        chk("t2_hold_instr_late", instr, 32'h0010_8113);
        chk("t2_hold_pc_late", pc_out, 32'h4);
        chk("t2_req_late", {31'b0, req}, 0);
        stall = 0;
        tick();
        chk("t2_skid_instr", instr, 32'h0000_0893);
        chk("t2_skid_pc", pc_out, 32'h8);
        chk("t2_resume_req", {31'b0, req}, 1);
        chk("t2_resume_addr", addr, 32'hC);
        tick(); tick();
        chk("t2_next_instr", instr, 32'h0000_0C93);
        chk("t2_next_pc", pc_out, 32'hC);
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_req_stable", {31'b0, req}, 1);
            chk("t3_addr_stable", addr, 32'h10);
        end
        ready = 1; lat = 1;
        tick();
        chk("t3_pc_adv", addr, 32'h14);
        chk("t3_wait_req", {31'b0, req}, 0);
        redirect = 1; pc_in = 32'h100;
        tick();
        redirect = 0;
        chk("t4_flush", {31'b0, flush}, 1);
        chk("t4_instr_nop", instr, 32'h13);
        chk("t4_valid", {31'b0, valid}, 0);
        chk("t4_drop_req", {31'b0, req}, 0);
        chk("t4_target", addr, 32'h100);
        tick();
        chk("t4_req_after_drop", {31'b0, req}, 1);
        chk("t4_addr_after_drop", addr, 32'h100);
        chk("t4_flush_stale", {31'b0, flush}, 1);
        lat = 0;
        tick();
        chk("t4_flush_wait", {31'b0, flush}, 1);
        chk("t4_instr_wait", instr, 32'h13);
        tick();
        chk("t4_new_instr", instr, 32'h0001_0093);
        chk("t4_new_pc", pc_out, 32'h100);
        chk("t4_new_flush", {31'b0, flush}, 0);
        chk("t4_new_valid", {31'b0, valid}, 1);
        lat = 3;
        tick();
        rst = 1;
        tick();
        chk("t5_rst_req", {31'b0, req}, 0);
        chk("t5_rst_addr", addr, 32'h0);
        chk("t5_rst_instr", instr, 32'h13);
        chk("t5_rst_pc", pc_out, 32'h0);
        chk("t5_rst_valid", {31'b0, valid}, 0);
        chk("t5_rst_flush", {31'b0, flush}, 1);
        rst = 0;
        tick();
        chk("t5_gated_req", {31'b0, req}, 0);
        tick();
        chk("t5_gated_req2", {31'b0, req}, 0);
        tick();
        chk("t5_late_ignored", instr, 32'h13);
        chk("t5_late_valid", {31'b0, valid}, 0);
        chk("t5_req", {31'b0, req}, 1);
        chk("t5_addr", addr, 32'h0);
        lat = 0;
        tick(); tick();
        chk("t5_first_instr", instr, 32'h0050_0093);
        chk("t5_first_pc", pc_out, 32'h0);
        chk("t5_first_flush", {31'b0, flush}, 0);
        ready = 0; redirect = 1; pc_in = 32'h300;
        tick();
        pc_in = 32'h400;
        tick();
        redirect = 0;
        chk("t6_b2b_addr", addr, 32'h400);
        chk("t6_b2b_req", {31'b0, req}, 1);
        chk("t6_b2b_flush", {31'b0, flush}, 1);
        chk("t6_b2b_valid", {31'b0, valid}, 0);
`ifdef MSRV32_MISALIGN_TRAP_EN
        redirect = 1; pc_in = 32'h102;
        tick();
        redirect = 0;
        chk("t7_mis_pulse", {31'b0, mis}, 1);
        chk("t7_mis_noreq", {31'b0, req}, 0);
        chk("t7_mis_flush", {31'b0, flush}, 1);
        tick();
        chk("t7_mis_clear", {31'b0, mis}, 0);
        chk("t7_mis_hold", {31'b0, req}, 0);
        redirect = 1; pc_in = 32'h200; ready = 1;
        tick();
        redirect = 0;
        chk("t7_resume_req", {31'b0, req}, 1);
        chk("t7_resume_addr", addr, 32'h200);
`else
        redirect = 1; pc_in = 32'h503;
        tick();
        redirect = 0;
        chk("t7_align_addr", addr, 32'h500);
        chk("t7_align_req", {31'b0, req}, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
